// File: rtl/vend_controller.sv
// Multi-product vending controller: coin credit, selection, stock,
// vend and serial greedy 5/2/1 change return.
module vend_controller #(
    parameter int NUM_PRODUCTS = 4,
    parameter int ID_W = $clog2(NUM_PRODUCTS),
    parameter int CREDIT_W = 6,
    parameter int MAX_CREDIT = 40,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
        {6'd8, 6'd2, 6'd5, 6'd3},
    parameter int STOCK_W = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin,
    input  logic                sel_valid,
    input  logic [ID_W-1:0]     sel_id,
    input  logic                cancel,
    input  logic                restock_valid,
    input  logic [ID_W-1:0]     restock_id,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                product_valid,
    output logic [ID_W-1:0]     product_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                done,
    output logic                coin_reject,
    output logic                sold_out
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_VEND    = 3'd2;
    localparam logic [2:0] S_CHANGE  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [STOCK_W-1:0]  STOCK_MAX = '1;
    localparam logic [STOCK_W-1:0]  STOCK_RST = STOCK_W'(STOCK_INIT);
    localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);

    logic [2:0]          state, state_d;
    logic [CREDIT_W-1:0] credit_d;
    logic                pend, pend_d;
    logic [ID_W-1:0]     pid, pid_d;
    logic [STOCK_W-1:0]  stock   [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  stock_d [NUM_PRODUCTS];

    logic                busy_d, pv_d, cv_d, done_d, rej_d, so_d;
    logic [ID_W-1:0]     pido_d;
    logic [1:0]          cc_d;

    logic [CREDIT_W-1:0] pend_price;
    logic [STOCK_W-1:0]  pend_stock, sel_stock;
    logic [CREDIT_W:0]   coin_val, coin_sum;
    logic                coin_ok, vend_ok;
    logic [CREDIT_W-1:0] chg_val;
    logic [1:0]          chg_code;

    // Table lookups, coin decode and greedy change coin choice
    always_comb begin
        pend_price = '0;
        pend_stock = '0;
        sel_stock  = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (pid == ID_W'(i)) begin
                pend_price = PRICES[i*CREDIT_W +: CREDIT_W];
                pend_stock = stock[i];
            end
            if (sel_id == ID_W'(i))
                sel_stock = stock[i];
        end
        case (coin)
            2'b01:   coin_val = (CREDIT_W+1)'(1);
            2'b10:   coin_val = (CREDIT_W+1)'(2);
            2'b11:   coin_val = (CREDIT_W+1)'(5);
            default: coin_val = '0;
        endcase
        coin_sum = {1'b0, credit} + coin_val;
        coin_ok  = (coin_val != '0) && (coin_sum <= MAX_C);
        vend_ok  = pend && (credit >= pend_price) && (pend_stock != '0);
        if (credit >= CREDIT_W'(5)) begin
            chg_val  = CREDIT_W'(5);
            chg_code = 2'b11;
        end else if (credit >= CREDIT_W'(2)) begin
            chg_val  = CREDIT_W'(2);
            chg_code = 2'b10;
        end else begin
            chg_val  = CREDIT_W'(1);
            chg_code = 2'b01;
        end
    end

    // Next-state, datapath and output pulse decisions
    always_comb begin
        state_d  = state;
        credit_d = credit;
        pend_d   = pend;
        pid_d    = pid;
        stock_d  = stock;
        pv_d     = 1'b0;
        pido_d   = '0;
        cv_d     = 1'b0;
        cc_d     = 2'b00;
        done_d   = 1'b0;
        rej_d    = 1'b0;
        so_d     = 1'b0;
        case (state)
            S_IDLE, S_COLLECT: begin
                if (cancel && state == S_COLLECT) begin
                    pend_d  = 1'b0;
                    rej_d   = coin_valid;
                    state_d = (credit != '0) ? S_CHANGE : S_DONE;
                end else if (state == S_COLLECT && vend_ok) begin
                    rej_d   = coin_valid;
                    state_d = S_VEND;
                end else begin
                    if (state == S_COLLECT && pend && pend_stock == '0) begin
                        pend_d = 1'b0;
                        so_d   = 1'b1;
                    end
                    if (coin_valid) begin
                        if (coin_ok) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                            state_d  = S_COLLECT;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                    if (sel_valid) begin
                        if (sel_stock != '0) begin
                            pend_d  = 1'b1;
                            pid_d   = sel_id;
                            state_d = S_COLLECT;
                        end else begin
                            so_d = 1'b1;
                        end
                    end
                end
            end
            S_VEND: begin
                pv_d     = 1'b1;
                pido_d   = pid;
                rej_d    = coin_valid;
                pend_d   = 1'b0;
                credit_d = credit - pend_price;
                for (int i = 0; i < NUM_PRODUCTS; i++)
                    if (pid == ID_W'(i))
                        stock_d[i] = stock[i] - 1'b1;
                state_d = (credit_d != '0) ? S_CHANGE : S_DONE;
            end
            S_CHANGE: begin
                cv_d     = 1'b1;
                cc_d     = chg_code;
                rej_d    = coin_valid;
                credit_d = credit - chg_val;
                if (credit_d == '0)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                rej_d   = coin_valid;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a refill overrides any decrement to the same product
        for (int i = 0; i < NUM_PRODUCTS; i++)
            if (restock_valid && restock_id == ID_W'(i))
                stock_d[i] = STOCK_MAX;
        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE) ||
                 (state_d == S_DONE);
    end

    // State, credit, stock and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            credit        <= '0;
            pend          <= 1'b0;
            pid           <= '0;
            for (int i = 0; i < NUM_PRODUCTS; i++)
                stock[i] <= STOCK_RST;
            busy          <= 1'b0;
            product_valid <= 1'b0;
            product_id    <= '0;
            change_valid  <= 1'b0;
            change_coin   <= 2'b00;
            done          <= 1'b0;
            coin_reject   <= 1'b0;
            sold_out      <= 1'b0;
        end else begin
            state         <= state_d;
            credit        <= credit_d;
            pend          <= pend_d;
            pid           <= pid_d;
            for (int i = 0; i < NUM_PRODUCTS; i++)
                stock[i] <= stock_d[i];
            busy          <= busy_d;
            product_valid <= pv_d;
            product_id    <= pido_d;
            change_valid  <= cv_d;
            change_coin   <= cc_d;
            done          <= done_d;
            coin_reject   <= rej_d;
            sold_out      <= so_d;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios and random traffic
// against a transaction-scheduling reference model.
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_id = 2'b00;
    logic [5:0] credit;
    logic       busy, product_valid, change_valid, done;
    logic       coin_reject, sold_out;
    logic [1:0] product_id, change_coin;

    vend_controller dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel_id(sel_id),
        .cancel(cancel),
        .restock_valid(restock_valid), .restock_id(restock_id),
        .credit(credit), .busy(busy),
        .product_valid(product_valid), .product_id(product_id),
        .change_valid(change_valid), .change_coin(change_coin),
        .done(done), .coin_reject(coin_reject), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit cv; bit [1:0] c; bit sv; bit [1:0] sid;
        bit can; bit rv; bit [1:0] rid;
    } stim_t;

    typedef struct {
        int credit; bit pv; int pid; bit cv; int cc; bit done;
    } ent_t;

    int tests = 0;
    int fails = 0;

    int price [4] = '{3, 5, 2, 8};
    int m_credit, m_pid;
    int m_stock [4];
    bit m_pend, m_collect;
    ent_t sched [$];
    bit e_busy, e_pv, e_cv, e_done, e_rej, e_so;
    int e_pid, e_cc;

    stim_t sq [$];
    int n_pv, last_pid, chg_sum, n_chg, n_c5, n_done, n_rej, n_so;

    function automatic stim_t mk(bit cv, bit [1:0] c, bit sv, bit [1:0] sid,
                                 bit can, bit rv, bit [1:0] rid);
        stim_t s;
        s.cv = cv; s.c = c; s.sv = sv; s.sid = sid;
        s.can = can; s.rv = rv; s.rid = rid;
        return s;
    endfunction

    function automatic stim_t mk_idle();
        return mk(0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic stim_t mk_coin(bit [1:0] c);
        return mk(1, c, 0, 0, 0, 0, 0);
    endfunction
    function automatic stim_t mk_sel(bit [1:0] id);
        return mk(0, 0, 1, id, 0, 0, 0);
    endfunction
    function automatic stim_t mk_cancel();
        return mk(0, 0, 0, 0, 1, 0, 0);
    endfunction
    function automatic stim_t mk_restock(bit [1:0] id);
        return mk(0, 0, 0, 0, 0, 1, id);
    endfunction

    function automatic int cval(bit [1:0] c);
        case (c)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int ccode(int v);
        if (v == 5) return 3;
        if (v == 2) return 2;
        return 1;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {credit, busy, product_valid, product_id, change_valid,
                change_coin, done, coin_reject, sold_out};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {6'(m_credit), e_busy, e_pv, 2'(e_pid), e_cv, 2'(e_cc),
                e_done, e_rej, e_so};
    endfunction

    task automatic model_reset();
        m_credit = 0; m_pid = 0; m_pend = 0; m_collect = 0;
        sched.delete();
        foreach (m_stock[i]) m_stock[i] = 5;
        e_busy = 0; e_pv = 0; e_cv = 0; e_done = 0; e_rej = 0; e_so = 0;
        e_pid = 0; e_cc = 0;
    endtask

    // Plan the change coins of a refund and the closing done cycle
    task automatic plan_refund(int c);
        ent_t e;
        int v;
        while (c > 0) begin
            v = (c >= 5) ? 5 : ((c >= 2) ? 2 : 1);
            c -= v;
            e = '{credit: c, pv: 0, pid: 0, cv: 1, cc: ccode(v), done: 0};
            sched.push_back(e);
        end
        e = '{credit: 0, pv: 0, pid: 0, cv: 0, cc: 0, done: 1};
        sched.push_back(e);
    endtask

    task automatic model_step(stim_t s);
        ent_t e;
        int v;
        e_pv = 0; e_cv = 0; e_done = 0; e_rej = 0; e_so = 0;
        e_pid = 0; e_cc = 0;
        if (sched.size() > 0) begin
            e = sched.pop_front();
            e_pv = e.pv; e_pid = e.pid; e_cv = e.cv; e_cc = e.cc;
            e_done = e.done;
            m_credit = e.credit;
            if (e.pv) m_stock[e.pid]--;
            e_rej = s.cv;
        end else if (s.can && m_collect) begin
            e_rej = s.cv;
            m_pend = 0;
            m_collect = 0;
            plan_refund(m_credit);
        end else if (m_collect && m_pend && m_credit >= price[m_pid] &&
                     m_stock[m_pid] > 0) begin
            e_rej = s.cv;
            e = '{credit: m_credit - price[m_pid], pv: 1, pid: m_pid,
                  cv: 0, cc: 0, done: 0};
            sched.push_back(e);
            plan_refund(m_credit - price[m_pid]);
            m_pend = 0;
            m_collect = 0;
        end else begin
            if (m_collect && m_pend && m_stock[m_pid] == 0) begin
                m_pend = 0;
                e_so = 1;
            end
            if (s.cv) begin
                v = cval(s.c);
                if (v != 0 && m_credit + v <= 40) begin
                    m_credit += v;
                    m_collect = 1;
                end else begin
                    e_rej = 1;
                end
            end
            if (s.sv) begin
                if (m_stock[int'(s.sid)] > 0) begin
                    m_pend = 1;
                    m_pid = int'(s.sid);
                    m_collect = 1;
                end else begin
                    e_so = 1;
                end
            end
        end
        if (s.rv) m_stock[int'(s.rid)] = 15;
        e_busy = (sched.size() != 0);
    endtask

    task automatic step(stim_t s);
        coin_valid = s.cv; coin = s.c;
        sel_valid = s.sv; sel_id = s.sid;
        cancel = s.can;
        restock_valid = s.rv; restock_id = s.rid;
        @(posedge clk);
        model_step(s);
        #1;
        coin_valid = 0; sel_valid = 0; cancel = 0; restock_valid = 0;
    endtask

    task automatic clear_stats();
        n_pv = 0; last_pid = -1; chg_sum = 0; n_chg = 0; n_c5 = 0;
        n_done = 0; n_rej = 0; n_so = 0;
    endtask

    task automatic tally();
        if (product_valid) begin
            n_pv++;
            last_pid = int'(product_id);
        end
        if (change_valid) begin
            chg_sum += cval(change_coin);
            n_chg++;
            if (change_coin == 2'b11) n_c5++;
        end
        n_done += int'(done);
        n_rej  += int'(coin_reject);
        n_so   += int'(sold_out);
    endtask

    task automatic add_vend0();
        sq.push_back(mk_coin(2'b01));
        sq.push_back(mk_coin(2'b10));
        sq.push_back(mk_sel(2'd0));
        repeat (3) sq.push_back(mk_idle());
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        #3;
        tests++;
        if (dut_vec() !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs got %h want 0000", dut_vec());
        end
        @(negedge clk);
        rst_n = 1;
        sq.delete();
        repeat (2) sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reset_idle cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        sq.delete();
        clear_stats();
        sq.push_back(mk_coin(2'b11));
        sq.push_back(mk_coin(2'b10));
        sq.push_back(mk_sel(2'd1));
        repeat (6) sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL basic cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            tally();
        end
        tests++;
        if (n_pv != 1 || last_pid != 1) begin
            fails++;
            $display("FAIL basic_vend got n=%0d id=%0d want n=1 id=1",
                     n_pv, last_pid);
        end
        tests++;
        if (chg_sum != 2 || n_done != 1 || credit !== 6'd0) begin
            fails++;
            $display("FAIL basic_change got sum=%0d done=%0d cr=%0d want 2 1 0",
                     chg_sum, n_done, credit);
        end
    endtask

    task automatic test_select_first();
        sq.delete();
        clear_stats();
        sq.push_back(mk_sel(2'd3));
        sq.push_back(mk_coin(2'b11));
        sq.push_back(mk_coin(2'b11));
        repeat (6) sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL selfirst cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            tally();
        end
        tests++;
        if (last_pid != 3 || chg_sum != 2 || n_done != 1) begin
            fails++;
            $display("FAIL selfirst_txn got id=%0d sum=%0d done=%0d want 3 2 1",
                     last_pid, chg_sum, n_done);
        end
    endtask

    task automatic test_overflow();
        logic [5:0] cr_rej;
        cr_rej = '0;
        sq.delete();
        clear_stats();
        repeat (7) sq.push_back(mk_coin(2'b11));
        sq.push_back(mk_coin(2'b10));
        sq.push_back(mk_coin(2'b01));
        sq.push_back(mk_coin(2'b11));
        sq.push_back(mk_cancel());
        repeat (11) sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL overflow cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            if (i == 9) cr_rej = credit;
            tally();
        end
        tests++;
        if (n_rej != 1 || cr_rej !== 6'd38) begin
            fails++;
            $display("FAIL overflow_reject got n=%0d cr=%0d want 1 38",
                     n_rej, cr_rej);
        end
        tests++;
        if (chg_sum != 38 || n_c5 != 7 || n_chg != 9 || n_done != 1) begin
            fails++;
            $display("FAIL overflow_refund got sum=%0d fives=%0d n=%0d done=%0d want 38 7 9 1",
                     chg_sum, n_c5, n_chg, n_done);
        end
    endtask

    task automatic test_sold_out();
        sq.delete();
        clear_stats();
        repeat (5) add_vend0();
        sq.push_back(mk_sel(2'd0));
        sq.push_back(mk_coin(2'b11));
        repeat (2) sq.push_back(mk_idle());
        sq.push_back(mk_cancel());
        repeat (3) sq.push_back(mk_idle());
        sq.push_back(mk_restock(2'd0));
        add_vend0();
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL soldout cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            tally();
        end
        tests++;
        if (n_so != 1 || n_pv != 6 || chg_sum != 5) begin
            fails++;
            $display("FAIL soldout_txn got so=%0d vends=%0d refund=%0d want 1 6 5",
                     n_so, n_pv, chg_sum);
        end
    endtask

    task automatic test_simultaneous();
        sq.delete();
        clear_stats();
        sq.push_back(mk_coin(2'b10));
        sq.push_back(mk(1, 2'b11, 0, 0, 1, 0, 0));
        repeat (3) sq.push_back(mk_idle());
        sq.push_back(mk_coin(2'b01));
        sq.push_back(mk(1, 2'b01, 1, 2'd2, 0, 0, 0));
        repeat (4) sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL simult cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            tally();
        end
        tests++;
        if (n_rej != 1 || chg_sum != 2 || n_chg != 1) begin
            fails++;
            $display("FAIL simult_cancel got rej=%0d sum=%0d n=%0d want 1 2 1",
                     n_rej, chg_sum, n_chg);
        end
        tests++;
        if (n_pv != 1 || last_pid != 2 || n_done != 2) begin
            fails++;
            $display("FAIL simult_exact got vends=%0d id=%0d done=%0d want 1 2 2",
                     n_pv, last_pid, n_done);
        end
    endtask

    task automatic test_reset_mid();
        sq.delete();
        sq.push_back(mk_restock(2'd0));
        add_vend0();
        repeat (3) sq.push_back(mk_coin(2'b11));
        sq.push_back(mk_cancel());
        sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_pre cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
        rst_n = 0;
        #1;
        model_reset();
        tests++;
        if (dut_vec() !== 16'h0) begin
            fails++;
            $display("FAIL midrst_outputs got %h want 0000", dut_vec());
        end
        #1;
        rst_n = 1;
        sq.delete();
        clear_stats();
        repeat (3) sq.push_back(mk_idle());
        repeat (5) add_vend0();
        sq.push_back(mk_sel(2'd0));
        sq.push_back(mk_idle());
        foreach (sq[i]) begin
            step(sq[i]);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_post cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            tally();
        end
        tests++;
        if (n_done != 5 || n_pv != 5 || n_so != 1) begin
            fails++;
            $display("FAIL midrst_stock got done=%0d vends=%0d so=%0d want 5 5 1",
                     n_done, n_pv, n_so);
        end
    endtask

    task automatic test_random();
        stim_t s;
        rst_n = 0;
        model_reset();
        #2;
        rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            s = mk(($urandom % 10) < 3, 2'($urandom_range(0, 3)),
                   ($urandom % 10) < 2, 2'($urandom_range(0, 3)),
                   ($urandom % 25) == 0, ($urandom % 40) == 0,
                   2'($urandom_range(0, 3)));
            step(s);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc %0d got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_select_first();
        test_overflow();
        test_sold_out();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
